// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 scancode parser.
// Prefix bytes, error bytes, key event bundle and parser states.
package ps2_pkg;

  localparam logic [7:0] PS2_E0   = 8'hE0;
  localparam logic [7:0] PS2_F0   = 8'hF0;
  localparam logic [7:0] PS2_E1   = 8'hE1;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    REL,
    EXTREL,
    SKIP
  } parse_state_t;

  function automatic logic is_err_byte(
    input logic [7:0] b
  );
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_scancode_parser_if.sv
// Key event valid/ready bundle between the parser and host logic.
// master = parser side, slave = consumer side.
interface ps2_scancode_parser_if;

  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_rel;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_ext,
    output ev_rel,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_ext,
    input  ev_rel,
    output ev_ready
  );

endinterface

// File: rtl/ps2_event_fifo.sv
// Small circular FIFO of key events; push and pop may share a cycle.
// When empty the output holds the last head value seen.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  key_event_t i_data,
  output logic       o_full,
  input  logic       i_pop,
  output logic       o_empty,
  output key_event_t o_data
);

  localparam int AW = $clog2(DEPTH);

  key_event_t    r_mem [DEPTH];
  key_event_t    r_last;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_data = o_empty ? r_last : r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_cnt <= r_cnt + (AW+1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_cnt <= r_cnt - (AW+1)'(1);
      end
      if (!o_empty) begin
        r_last <= r_mem[r_rd];
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_parser.sv
// Folds PS/2 prefix bytes into key events and queues them for the host.
// Optional PS2_TYPEMATIC_FILTER_EN drops repeated makes of the held key.
module ps2_scancode_parser
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            code,
  input  logic                  done,
  ps2_scancode_parser_if.master ev,
  output logic                  overflow,
  output logic                  kbd_err
);

  parse_state_t r_state;
  parse_state_t w_nstate;
  logic [2:0]   r_skip;
  logic [2:0]   w_nskip;
  logic         r_d1;
  logic         r_d2;
  logic         r_d3;
  logic         r_ovf;
  logic         r_err;
  logic         w_stb;
  logic         w_emit;
  logic         w_err;
  logic         w_drop;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  key_event_t   w_ev;
  key_event_t   w_head;
  logic         w_is_e0;
  logic         w_is_f0;
  logic         w_is_e1;
  logic         w_is_err;

  // code is stable while done is high, so it is used directly on the strobe
  assign w_stb    = r_d2 & ~r_d3;
  assign w_is_e0  = (code == PS2_E0);
  assign w_is_f0  = (code == PS2_F0);
  assign w_is_e1  = (code == PS2_E1);
  assign w_is_err = is_err_byte(code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= 1'b0;
      r_d2 <= 1'b0;
      r_d3 <= 1'b0;
    end else begin
      r_d1 <= done;
      r_d2 <= r_d1;
      r_d3 <= r_d2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_nstate;
      r_skip  <= w_nskip;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nskip  = r_skip;
    w_emit   = 1'b0;
    w_err    = 1'b0;
    w_ev     = '0;
    if (w_stb) begin
      unique case (r_state)
        IDLE: begin
          unique case (1'b1)
            w_is_e0: w_nstate = EXT;
            w_is_f0: w_nstate = REL;
            w_is_e1: begin
              w_nstate = SKIP;
              w_nskip  = 3'd7;
            end
            w_is_err: w_err = 1'b1;
            default: begin
              w_emit = 1'b1;
              w_ev   = '{ext: 1'b0, rel: 1'b0, code: code};
            end
          endcase
        end
        EXT: begin
          unique case (1'b1)
            w_is_f0: w_nstate = EXTREL;
            w_is_err: begin
              w_err    = 1'b1;
              w_nstate = IDLE;
            end
            default: begin
              w_emit   = 1'b1;
              w_ev     = '{ext: 1'b1, rel: 1'b0, code: code};
              w_nstate = IDLE;
            end
          endcase
        end
        REL: begin
          w_nstate = IDLE;
          if (w_is_err) begin
            w_err = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_ev   = '{ext: 1'b0, rel: 1'b1, code: code};
          end
        end
        EXTREL: begin
          w_nstate = IDLE;
          if (w_is_err) begin
            w_err = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_ev   = '{ext: 1'b1, rel: 1'b1, code: code};
          end
        end
        SKIP: begin
          // Pause: E1 plus seven bytes collapse into one extended E1 make
          w_nskip = r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            w_emit   = 1'b1;
            w_ev     = '{ext: 1'b1, rel: 1'b0, code: PS2_E1};
            w_nstate = IDLE;
          end
        end
        default: w_nstate = IDLE;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       r_lm_vld;
  logic       r_lm_ext;
  logic [7:0] r_lm_code;
  logic       w_lm_hit;

  assign w_lm_hit = r_lm_vld &&
                    (r_lm_ext == w_ev.ext) &&
                    (r_lm_code == w_ev.code);
  assign w_drop   = w_emit & ~w_ev.rel & w_lm_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lm_vld  <= 1'b0;
      r_lm_ext  <= 1'b0;
      r_lm_code <= '0;
    end else if (w_emit) begin
      if (!w_ev.rel) begin
        if (!w_lm_hit) begin
          r_lm_vld  <= 1'b1;
          r_lm_ext  <= w_ev.ext;
          r_lm_code <= w_ev.code;
        end
      end else if (w_lm_hit) begin
        r_lm_vld <= 1'b0;
      end
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  assign w_push = w_emit & ~w_drop;
  assign w_pop  = ev.ev_ready & ~w_empty;

  ps2_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_ev),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_data  (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovf <= w_push & w_full & ~w_pop;
      r_err <= w_err;
    end
  end

  assign ev.ev_valid = ~w_empty;
  assign ev.ev_code  = w_head.code;
  assign ev.ev_ext   = w_head.ext;
  assign ev.ev_rel   = w_head.rel;
  assign overflow    = r_ovf;
  assign kbd_err     = r_err;

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Scoreboard bench for ps2_scancode_parser: a sequence-level byte model
// predicts key events; a negedge monitor compares each accepted event.
`timescale 1ns/1ps
module tb_ps2_scancode_parser;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code = 8'h00;
  logic       done = 1'b0;
  logic       overflow;
  logic       kbd_err;

  ps2_scancode_parser_if ev_if ();

  ps2_scancode_parser #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .code     (code),
    .done     (done),
    .ev       (ev_if),
    .overflow (overflow),
    .kbd_err  (kbd_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_ovf = 0;
  int n_err = 0;
  int exp_ovf = 0;
  int exp_err = 0;
  int low_run = 0;
  bit rnd_mode = 1'b0;
  logic ready_dir = 1'b1;

  ps2_pkg::key_event_t exp_q[$];
  logic [7:0] seq[$];
  logic       lm_vld = 1'b0;
  logic       lm_ext = 1'b0;
  logic [7:0] lm_code = 8'h00;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect bytes of one key sequence, decide when complete
  task automatic model_byte(input logic [7:0] b);
    ps2_pkg::key_event_t e;
    bit fire;
    bit keep;
    fire = 1'b0;
    keep = 1'b1;
    e = '0;
    seq.push_back(b);
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) begin
        e = '{ext: 1'b1, rel: 1'b0, code: 8'hE1};
        fire = 1'b1;
        seq.delete();
      end
    end else if (b == 8'h00 || b == 8'hFF) begin
      exp_err++;
      seq.delete();
    end else if ((seq.size() == 1 && (b == 8'hE0 || b == 8'hF0)) ||
                 (seq.size() == 2 && seq[0] == 8'hE0 && b == 8'hF0)) begin
      fire = 1'b0;
    end else begin
      e.ext  = (seq[0] == 8'hE0);
      e.rel  = (seq[0] == 8'hF0) || (seq.size() == 3);
      e.code = b;
      fire = 1'b1;
      seq.delete();
    end
    if (fire) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!e.rel) begin
        if (lm_vld && lm_ext == e.ext && lm_code == e.code) keep = 1'b0;
        else begin
          lm_vld = 1'b1;
          lm_ext = e.ext;
          lm_code = e.code;
        end
      end else if (lm_vld && lm_ext == e.ext && lm_code == e.code) begin
        lm_vld = 1'b0;
      end
`endif
      if (keep) begin
        if (exp_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    code = b;
    done = 1'b1;
    model_byte(b);
    repeat (3) @(posedge clk);
    #1;
    done = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    ready_dir = 1'b1;
    while ((exp_q.size() != 0 || ev_if.ev_valid) && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd_mode) begin
      if (low_run >= 2 || $urandom_range(0, 3) != 0) begin
        ev_if.ev_ready = 1'b1;
        low_run = 0;
      end else begin
        ev_if.ev_ready = 1'b0;
        low_run++;
      end
    end else begin
      ev_if.ev_ready = ready_dir;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      ps2_pkg::key_event_t act;
      ps2_pkg::key_event_t exp;
      if (overflow) n_ovf++;
      if (kbd_err) n_err++;
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        act = '{ext: ev_if.ev_ext, rel: ev_if.ev_rel, code: ev_if.ev_code};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_event: got %0h, expected none", act);
        end else begin
          exp = exp_q.pop_front();
          check("event", 32'(act), 32'(exp));
        end
      end
    end
  end

  initial begin
    logic [7:0] pause[8];
    logic [7:0] typ[6];
    int r;
    pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    typ   = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_code", 32'(ev_if.ev_code), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(kbd_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // latency: valid must rise exactly two edges after the sampling edge
    @(posedge clk);
    #1;
    code = 8'h1C;
    done = 1'b1;
    model_byte(8'h1C);
    @(posedge clk);
    @(negedge clk);
    check("lat_k", 32'(ev_if.ev_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_k1", 32'(ev_if.ev_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_k2", 32'(ev_if.ev_valid), 32'd1);
    @(posedge clk);
    #1;
    done = 1'b0;
    repeat (5) @(posedge clk);
    drain("drain_lat");

    send(8'hF0);
    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'hE0);
    send(8'hE0);
    drain("drain_prefix");

    for (int i = 0; i < 8; i++) send(pause[i]);
    send(8'h1C);
    drain("drain_pause");

    ready_dir = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) send(8'(8'h11 * (i + 1)));
    repeat (4) @(posedge clk);
    check("full_valid", 32'(ev_if.ev_valid), 32'd1);
    check("ovf_once", 32'(n_ovf), 32'd1);
    check("ovf_model", 32'(n_ovf), 32'(exp_ovf));
    drain("drain_full");

    send(8'hFF);
    send(8'h2A);
    repeat (3) @(posedge clk);
    check("err_count", 32'(n_err), 32'(exp_err));
    drain("drain_err");

    for (int i = 0; i < 6; i++) send(typ[i]);
    drain("drain_typematic");

    ready_dir = 1'b0;
    repeat (2) @(posedge clk);
    send(8'h1C);
    send(8'h29);
    send(8'hE0);
    check("pre_rst_valid", 32'(ev_if.ev_valid), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ev_if.ev_valid), 32'd0);
    exp_q.delete();
    seq.delete();
    lm_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_dir = 1'b1;
    send(8'h75);
    drain("drain_reset");

    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 2) send(8'hE0);
      else if (r < 4) send(8'hF0);
      else if (r == 4) send(8'hE1);
      else if (r == 5) send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
      else send(8'($urandom_range(1, 8'hDF)));
    end
    rnd_mode = 1'b0;
    drain("drain_random");
    check("final_ovf", 32'(n_ovf), 32'(exp_ovf));
    check("final_err", 32'(n_err), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
